// File: rtl/mems_dac_spi_tx_if.sv
// rtl/mems_dac_spi_tx_if.sv - start/busy handshake and DAC pin bundle for mems_dac_spi_tx
interface mems_dac_spi_tx_if #(
  parameter int WORD_W = 24
);
  logic              start;
  logic [WORD_W-1:0] data;
  logic              busy;
  logic              frame_done;
  logic              spi_sclk;
  logic              spi_sync_n;
  logic              spi_mosi;
  logic [15:0]       frame_cnt;

  modport master (
    output start, data,
    input  busy, frame_done, spi_sclk, spi_sync_n, spi_mosi, frame_cnt
  );

  modport slave (
    input  start, data,
    output busy, frame_done, spi_sclk, spi_sync_n, spi_mosi, frame_cnt
  );
endinterface

// File: rtl/mems_dac_spi_tx.sv
// rtl/mems_dac_spi_tx.sv - 24-bit SYNC_n-framed SPI transmitter for the MEMS mirror quad DAC
// Optional completed-frame counter enabled by MEMS_SPI_FRAME_CNT_EN.
module mems_dac_spi_tx #(
  parameter int CLK_DIV  = 4,
  parameter int SYNC_GAP = 4,
  parameter int WORD_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  mems_dac_spi_tx_if.slave   bus
);
  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(SYNC_GAP + 1);
  localparam logic [HW-1:0] HALF_LOAD = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(SYNC_GAP - 1);
  localparam logic [4:0]    BIT_LOAD  = 5'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [4:0]        bit_q, bit_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sclk_q, sclk_d;
  logic              sync_n_q, sync_n_d;
  logic              mosi_q, mosi_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      gcnt_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      mosi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      gcnt_q   <= gcnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      mosi_q   <= mosi_d;
    end
  end

  // Next-state and next-output values; every output leaves through a register.
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    gcnt_d   = gcnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    busy_d   = busy_q;
    sclk_d   = sclk_q;
    sync_n_d = sync_n_q;
    mosi_d   = mosi_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d   = 1'b0;
        sync_n_d = 1'b1;
        sclk_d   = 1'b1;
        mosi_d   = 1'b0;
        if (bus.start) begin
          state_d  = SETUP;
          shreg_d  = bus.data;
          bit_d    = BIT_LOAD;
          hcnt_d   = HALF_LOAD;
          busy_d   = 1'b1;
          sync_n_d = 1'b0;
          mosi_d   = bus.data[WORD_W-1];
        end
      end

      SETUP: begin
        if (hcnt_q == '0) begin
          state_d = SHIFT_LO;
          sclk_d  = 1'b0;
          hcnt_d  = HALF_LOAD;
        end else begin
          hcnt_d = hcnt_q - HW'(1);
        end
      end

      // MOSI advances on the rising edge so it settles a full half-period before the DAC samples.
      SHIFT_LO: begin
        if (hcnt_q == '0) begin
          state_d = SHIFT_HI;
          sclk_d  = 1'b1;
          hcnt_d  = HALF_LOAD;
          shreg_d = shreg_q << 1;
          mosi_d  = shreg_q[WORD_W-2];
        end else begin
          hcnt_d = hcnt_q - HW'(1);
        end
      end

      SHIFT_HI: begin
        if (hcnt_q == '0) begin
          if (bit_q == 5'd0) begin
            state_d  = GAP;
            sync_n_d = 1'b1;
            mosi_d   = 1'b0;
            done_d   = 1'b1;
            gcnt_d   = GAP_LOAD;
          end else begin
            state_d = SHIFT_LO;
            sclk_d  = 1'b0;
            hcnt_d  = HALF_LOAD;
            bit_d   = bit_q - 5'd1;
          end
        end else begin
          hcnt_d = hcnt_q - HW'(1);
        end
      end

      GAP: begin
        if (gcnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.spi_sclk   = sclk_q;
  assign bus.spi_sync_n = sync_n_q;
  assign bus.spi_mosi   = mosi_q;

`ifdef MEMS_SPI_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (done_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
`else
  assign bus.frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mems_dac_spi_tx.sv
// tb/tb_mems_dac_spi_tx.sv - directed bench for mems_dac_spi_tx (default and CLK_DIV=1/SYNC_GAP=1 instances)
module tb_mems_dac_spi_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

`ifdef MEMS_SPI_FRAME_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  mems_dac_spi_tx_if #(.WORD_W(24)) ifa ();
  mems_dac_spi_tx_if #(.WORD_W(24)) ifb ();

  mems_dac_spi_tx #(.CLK_DIV(4), .SYNC_GAP(4), .WORD_W(24)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  mems_dac_spi_tx #(.CLK_DIV(1), .SYNC_GAP(1), .WORD_W(24)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_cnt_a = 0;
  int exp_cnt_b = 0;

  // Line monitors: sample away from the active edge, accumulate running totals.
  logic        prev_sclk_a = 1'b1;
  int          fall_low_a = 0, fall_high_a = 0, done_a = 0;
  logic [23:0] word_a = '0;
  int          busy_run_a = 0, busy_len_a = 0, idle_run_a = 0, idle_len_a = 0;
  int          slow_run_a = 0, slow_len_a = 0, shigh_run_a = 0, shigh_len_a = 0;

  always @(negedge clk) begin
    prev_sclk_a <= ifa.spi_sclk;
    if (prev_sclk_a && !ifa.spi_sclk) begin
      if (!ifa.spi_sync_n) begin
        fall_low_a <= fall_low_a + 1;
        word_a     <= {word_a[22:0], ifa.spi_mosi};
      end else begin
        fall_high_a <= fall_high_a + 1;
      end
    end
    if (ifa.frame_done) done_a <= done_a + 1;
    busy_run_a <= ifa.busy ? busy_run_a + 1 : 0;
    if (!ifa.busy && busy_run_a != 0) busy_len_a <= busy_run_a;
    idle_run_a <= ifa.busy ? 0 : idle_run_a + 1;
    if (ifa.busy && idle_run_a != 0) idle_len_a <= idle_run_a;
    slow_run_a <= ifa.spi_sync_n ? 0 : slow_run_a + 1;
    if (ifa.spi_sync_n && slow_run_a != 0) slow_len_a <= slow_run_a;
    shigh_run_a <= ifa.spi_sync_n ? shigh_run_a + 1 : 0;
    if (!ifa.spi_sync_n && shigh_run_a != 0) shigh_len_a <= shigh_run_a;
  end

  logic        prev_sclk_b = 1'b1;
  int          fall_low_b = 0, fall_high_b = 0, done_b = 0;
  logic [23:0] word_b = '0;
  int          busy_run_b = 0, busy_len_b = 0, slow_run_b = 0, slow_len_b = 0;

  always @(negedge clk) begin
    prev_sclk_b <= ifb.spi_sclk;
    if (prev_sclk_b && !ifb.spi_sclk) begin
      if (!ifb.spi_sync_n) begin
        fall_low_b <= fall_low_b + 1;
        word_b     <= {word_b[22:0], ifb.spi_mosi};
      end else begin
        fall_high_b <= fall_high_b + 1;
      end
    end
    if (ifb.frame_done) done_b <= done_b + 1;
    busy_run_b <= ifb.busy ? busy_run_b + 1 : 0;
    if (!ifb.busy && busy_run_b != 0) busy_len_b <= busy_run_b;
    slow_run_b <= ifb.spi_sync_n ? 0 : slow_run_b + 1;
    if (ifb.spi_sync_n && slow_run_b != 0) slow_len_b <= slow_run_b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic cur_busy(input int sel);
    return (sel != 0) ? ifb.busy : ifa.busy;
  endfunction

  task automatic wait_idle(input int sel, input string name);
    int n;
    n = 0;
    while (cur_busy(sel) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 2000), 32'd1);
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    int          sel;
    logic [23:0] data;
    int          exp_busy;
    int          exp_sync;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int f0, h0, d0;
    f0 = (v.sel != 0) ? fall_low_b : fall_low_a;
    h0 = (v.sel != 0) ? fall_high_b : fall_high_a;
    d0 = (v.sel != 0) ? done_b : done_a;
    @(negedge clk);
    if (v.sel != 0) begin ifb.data = v.data; ifb.start = 1'b1; end
    else            begin ifa.data = v.data; ifa.start = 1'b1; end
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    wait_idle(v.sel, "vec_timeout");
    if (v.sel != 0) begin
      exp_cnt_b = CNT_EN ? ((exp_cnt_b + 1) & 16'hFFFF) : 0;
      check("vec_word",       32'(word_b), 32'(v.data));
      check("vec_falls_low",  fall_low_b - f0, 24);
      check("vec_falls_high", fall_high_b - h0, 0);
      check("vec_done",       done_b - d0, 1);
      check("vec_busy_len",   busy_len_b, v.exp_busy);
      check("vec_sync_len",   slow_len_b, v.exp_sync);
      check("vec_frame_cnt",  32'(ifb.frame_cnt), exp_cnt_b);
    end else begin
      exp_cnt_a = CNT_EN ? ((exp_cnt_a + 1) & 16'hFFFF) : 0;
      check("vec_word",       32'(word_a), 32'(v.data));
      check("vec_falls_low",  fall_low_a - f0, 24);
      check("vec_falls_high", fall_high_a - h0, 0);
      check("vec_done",       done_a - d0, 1);
      check("vec_busy_len",   busy_len_a, v.exp_busy);
      check("vec_sync_len",   slow_len_a, v.exp_sync);
      check("vec_frame_cnt",  32'(ifa.frame_cnt), exp_cnt_a);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   d0, f0, n;

    vecs[0] = '{0, 24'h280001, 200, 196};
    vecs[1] = '{0, 24'h000000, 200, 196};
    vecs[2] = '{0, 24'hFFFFFF, 200, 196};
    vecs[3] = '{0, 24'h800001, 200, 196};
    vecs[4] = '{1, 24'hAAAAAA, 50, 49};
    vecs[5] = '{1, 24'h555555, 50, 49};

    // Reset with start asserted: reset must win.
    ifa.start = 1'b1; ifa.data = 24'hFFFFFF;
    ifb.start = 1'b1; ifb.data = 24'hFFFFFF;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_prio_busy_a", 32'(ifa.busy), 0);
    check("rst_prio_busy_b", 32'(ifb.busy), 0);
    rst = 1'b0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    @(negedge clk);
    check("reset_busy",       32'(ifa.busy), 0);
    check("reset_frame_done", 32'(ifa.frame_done), 0);
    check("reset_sclk",       32'(ifa.spi_sclk), 1);
    check("reset_sync_n",     32'(ifa.spi_sync_n), 1);
    check("reset_mosi",       32'(ifa.spi_mosi), 0);
    check("reset_frame_cnt",  32'(ifa.frame_cnt), 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Start during a frame is ignored, and data changes after acceptance have no effect.
    d0 = done_a;
    @(negedge clk);
    ifa.data = 24'h1F8000; ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (49) @(negedge clk);
    ifa.data = 24'hFFFFFF; ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    wait_idle(0, "ignore_timeout");
    exp_cnt_a = CNT_EN ? ((exp_cnt_a + 1) & 16'hFFFF) : 0;
    check("ignore_word",     32'(word_a), 32'h1F8000);
    check("ignore_busy_len", busy_len_a, 200);
    repeat (5) @(negedge clk);
    check("ignore_no_queue", 32'(ifa.busy), 0);
    check("ignore_done",     done_a - d0, 1);

    // Start held high: three back-to-back frames.
    d0 = done_a;
    f0 = fall_low_a;
    @(negedge clk);
    ifa.data = 24'h18A5A5; ifa.start = 1'b1;
    n = 0;
    while ((done_a - d0) < 3 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    ifa.start = 1'b0;
    check("b2b_reach3", 32'(n < 3000), 1);
    wait_idle(0, "b2b_timeout");
    exp_cnt_a = CNT_EN ? ((exp_cnt_a + 3) & 16'hFFFF) : 0;
    check("b2b_done",      done_a - d0, 3);
    check("b2b_falls",     fall_low_a - f0, 72);
    check("b2b_word",      32'(word_a), 32'h18A5A5);
    check("b2b_sync_high", shigh_len_a, 5);
    check("b2b_idle_gap",  idle_len_a, 1);
    check("b2b_busy_len",  busy_len_a, 200);
    check("b2b_frame_cnt", 32'(ifa.frame_cnt), exp_cnt_a);

    // Reset at the 10th falling edge aborts the frame.
    d0 = done_a;
    f0 = fall_low_a;
    @(negedge clk);
    ifa.data = 24'hC3C3C3; ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    n = 0;
    while ((fall_low_a - f0) < 10 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("abort_reach10", 32'(n < 1000), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    check("abort_sync_n",     32'(ifa.spi_sync_n), 1);
    check("abort_sclk",       32'(ifa.spi_sclk), 1);
    check("abort_busy",       32'(ifa.busy), 0);
    check("abort_mosi",       32'(ifa.spi_mosi), 0);
    repeat (10) @(negedge clk);
    #1;
    check("abort_no_done",    done_a - d0, 0);
    check("abort_frame_cnt",  32'(ifa.frame_cnt), 0);
    run_vec('{0, 24'h5A0F3C, 200, 196});

`ifdef MEMS_SPI_FRAME_CNT_EN
    // Counter wrap from 16'hFFFF.
    @(negedge clk);
    force dut_a.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut_a.frame_cnt_q;
    exp_cnt_a = 16'hFFFF;
    check("wrap_preload", 32'(ifa.frame_cnt), 32'hFFFF);
    run_vec('{0, 24'h0F0F0F, 200, 196});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
